// File: rtl/dedisp_channel_sum.sv
// dedisp_channel_sum: sums one spectrum of delayed channel samples, flags threshold crossings with holdoff
module dedisp_channel_sum #(
  parameter int N_CHANNELS = 64,
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = DIN_WIDTH + $clog2(N_CHANNELS),
  parameter int HOLDOFF    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic                  sync_in,
  input  logic [DOUT_WIDTH-1:0] threshold,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  trigger,
  output logic [31:0]           spec_count,
  output logic                  sync_err
);
  localparam int CW = $clog2(N_CHANNELS);
  localparam int HW = $clog2(HOLDOFF + 1);
  logic [CW-1:0]         ch_q, ch_d;
  logic [DOUT_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d, sum;
  logic [HW-1:0]         ho_q, ho_d;
  logic [31:0]           spec_count_q, spec_count_d;
  logic                  aligned_q, aligned_d, dout_valid_q, dout_valid_d;
  logic                  trigger_q, trigger_d, sync_err_q, sync_err_d;
  logic                  last, trig;
  always_comb begin
    sum          = acc_q + DOUT_WIDTH'(din);
    last         = ch_q == CW'(N_CHANNELS - 1);
    trig         = (sum > threshold) && (ho_q == '0);
    ch_d         = ch_q;
    acc_d        = acc_q;
    ho_d         = ho_q;
    aligned_d    = aligned_q;
    dout_d       = dout_q;
    spec_count_d = spec_count_q;
    dout_valid_d = 1'b0;
    trigger_d    = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      if (sync_in) begin
        // ch is only non-zero while aligned, so a non-zero ch marks a misplaced sync
        ch_d       = CW'(1);
        acc_d      = DOUT_WIDTH'(din);
        aligned_d  = 1'b1;
        sync_err_d = ch_q != '0;
      end else if (aligned_q) begin
        if (last) begin
          ch_d         = '0;
          acc_d        = '0;
          dout_d       = sum;
          dout_valid_d = 1'b1;
          trigger_d    = trig;
          spec_count_d = spec_count_q + 32'd1;
          ho_d         = trig ? HW'(HOLDOFF) : (ho_q != '0 ? ho_q - HW'(1) : ho_q);
        end else begin
          ch_d  = ch_q + CW'(1);
          acc_d = sum;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q         <= '0;
      acc_q        <= '0;
      ho_q         <= '0;
      aligned_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      trigger_q    <= 1'b0;
      spec_count_q <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      acc_q        <= acc_d;
      ho_q         <= ho_d;
      aligned_q    <= aligned_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      trigger_q    <= trigger_d;
      spec_count_q <= spec_count_d;
      sync_err_q   <= sync_err_d;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign trigger    = trigger_q;
  assign spec_count = spec_count_q;
  assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_dedisp_channel_sum.sv
// tb_dedisp_channel_sum: directed stimulus with a queue-based scoreboard and output monitor
module tb_dedisp_channel_sum;
  localparam int N = 4, DW = 8, OW = 10, HO = 2;
  logic          clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0, sync_in = 1'b0;
  logic [OW-1:0] threshold = '1;
  logic [OW-1:0] dout;
  logic          dout_valid, trigger, sync_err;
  logic [31:0]   spec_count;
  typedef struct {
    logic [OW-1:0] d;
    logic          t;
    logic [31:0]   c;
    int            cy;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0, serr = 0;

  dedisp_channel_sum #(.N_CHANNELS(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync_in(sync_in),
    .threshold(threshold), .dout(dout), .dout_valid(dout_valid), .trigger(trigger),
    .spec_count(spec_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    @(posedge clk); #1;
    din = d; sync_in = s; din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      din = '0; sync_in = 1'b0; din_valid = 1'b0;
    end
  endtask

  // expected result appears on the cycle after the last sample is captured
  task automatic push(input logic [OW-1:0] d, input logic t, input logic [31:0] c);
    exp_t x;
    x.d = d; x.t = t; x.c = c; x.cy = cyc + 1;
    q.push_back(x);
  endtask

  task automatic spec4(input logic [DW-1:0] a, b, c, d, input logic t, input logic [31:0] cnt);
    logic [OW-1:0] s;
    s = OW'(a) + OW'(b) + OW'(c) + OW'(d);
    send(a, 1'b1); send(b, 1'b0); send(c, 1'b0); send(d, 1'b0);
    push(s, t, cnt);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; din = 8'd7; sync_in = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din = '0; sync_in = 1'b0; din_valid = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_spec_count", spec_count, 0);
    chk("rst_sync_err", sync_err, 0);
  endtask

  always @(negedge clk) begin
    if (sync_err) serr++;
    if (trigger && !dout_valid) begin
      tests++; fails++;
      $display("FAIL trigger_without_valid: got 1 expected 0");
    end
    if (dout_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_dout: got dout=%0d expected no output", dout);
      end else begin
        e = q.pop_front();
        chk("dout", 32'(dout), 32'(e.d));
        chk("trigger", 32'(trigger), 32'(e.t));
        chk("spec_count", spec_count, e.c);
        chk("latency_cycle", cyc, e.cy);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    spec4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 32'd1);
    idle(3);
    chk("dout_hold", 32'(dout), 10);
    send(8'd255, 1'b1); idle(3);
    send(8'd255, 1'b0); idle(3);
    send(8'd255, 1'b0); idle(3);
    send(8'd255, 1'b0);
    push(10'd1020, 1'b0, 32'd2);
    idle(3);
    do_reset();
    send(8'd5, 1'b0); send(8'd5, 1'b0);
    spec4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 32'd1);
    idle(2);
    chk("no_sync_err_unaligned", serr, 0);
    send(8'd3, 1'b1); send(8'd3, 1'b0); send(8'd2, 1'b1);
    send(8'd2, 1'b0); send(8'd2, 1'b0); send(8'd2, 1'b0);
    push(10'd8, 1'b0, 32'd2);
    idle(2);
    chk("sync_err_count", serr, 1);
    threshold = 10'd9;
    for (int i = 0; i < 5; i++) spec4(8'd1, 8'd2, 8'd3, 8'd4, (i == 0) || (i == 3), 32'(3 + i));
    idle(3);
    send(8'd1, 1'b1); send(8'd2, 1'b0);
    do_reset();
    spec4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 32'd1);
    idle(3);
    chk("pending_expected", q.size(), 0);
    chk("sync_err_total", serr, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
